// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage; commits exec results to GPRs/PC.
// Optional retire counter enabled by WB_RETIRE_COUNTER_EN.
module writeback_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FLUSH_DEPTH = 2,
  parameter int          XLEN        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [4:0]    in_rd,
  input  logic          in_rd_we,
  input  logic [31:0]   in_rd_value,
  input  logic          in_redirect,
  input  logic [31:0]   in_next_pc_reg,
  input  logic          hold,
  output logic [31:0]   curr_pc_reg,
  output logic [1023:0] curr_general_reg,
  output logic          flush,
  output logic          misalign_err,
  output logic [63:0]   retire_cnt
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("writeback_stage supports XLEN=32 only");
  end

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0] FCNT_INIT = 4'(FLUSH_DEPTH - 1);

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [31:0] gpr [1:31];
  logic        acc;
  logic        commit;
  logic [31:0] tgt;

  assign in_ready = !hold && (state != HALT);
  assign acc      = in_valid && in_ready;
  assign commit   = acc && (state == RUN);
  assign tgt      = in_next_pc_reg & ~32'h1;

  // control FSM: PC update, flush window, halt on misaligned target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      flush_cnt    <= '0;
      flush        <= 1'b0;
      misalign_err <= 1'b0;
      curr_pc_reg  <= RESET_PC;
    end else begin
      case (state)
        RUN: begin
          if (acc) begin
            if (in_redirect) begin
              if (tgt[1]) begin
                state        <= HALT;
                misalign_err <= 1'b1;
              end else begin
                curr_pc_reg <= tgt;
                state       <= FLUSH;
                flush       <= 1'b1;
                flush_cnt   <= FCNT_INIT;
              end
            end else begin
              curr_pc_reg <= in_pc + 32'd4;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        HALT: begin
          misalign_err <= 1'b1;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  // register file write port; x0 is not stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        gpr[i] <= '0;
      end
    end else if (commit && in_rd_we && (in_rd != 5'd0)) begin
      gpr[in_rd] <= in_rd_value;
    end
  end

  // flatten register file for exec, x0 hardwired to zero
  always_comb begin
    curr_general_reg = '0;
    for (int i = 1; i < 32; i++) begin
      curr_general_reg[32*i +: 32] = gpr[i];
    end
  end

`ifdef WB_RETIRE_COUNTER_EN
  logic [63:0] rcnt;

  // count every committed beat, misaligned redirects included
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
    end else if (commit) begin
      rcnt <= rcnt + 64'd1;
    end
  end

  assign retire_cnt = rcnt;
`else
  assign retire_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: randomized scoreboard bench for writeback_stage.
// Reference model tracks architectural state and flush window by edge index.
module tb_writeback_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int          D   = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [4:0]    in_rd;
  logic          in_rd_we;
  logic [31:0]   in_rd_value;
  logic          in_redirect;
  logic [31:0]   in_next_pc_reg;
  logic          hold;
  logic [31:0]   curr_pc_reg;
  logic [1023:0] curr_general_reg;
  logic          flush;
  logic          misalign_err;
  logic [63:0]   retire_cnt;

  writeback_stage #(
    .RESET_PC(RPC),
    .FLUSH_DEPTH(D),
    .XLEN(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_pc(in_pc),
    .in_rd(in_rd),
    .in_rd_we(in_rd_we),
    .in_rd_value(in_rd_value),
    .in_redirect(in_redirect),
    .in_next_pc_reg(in_next_pc_reg),
    .hold(hold),
    .curr_pc_reg(curr_pc_reg),
    .curr_general_reg(curr_general_reg),
    .flush(flush),
    .misalign_err(misalign_err),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc;
    logic [1023:0] gpr;
    logic          mis;
    logic [63:0]   ret;
  } exp_t;

  exp_t        q[$];
  int          tests;
  int          fails;
  int          cyc;
  int          kred;
  logic [31:0] m_pc;
  logic [31:0] m_x [32];
  logic        m_halt;
  logic [63:0] m_ret;
  logic        pend;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic logic [1023:0] m_flat();
    logic [1023:0] f;
    f = '0;
    for (int i = 1; i < 32; i++) f[32*i +: 32] = m_x[i];
    return f;
  endfunction

  task automatic chk_gpr(input string nm, input logic [1023:0] exp);
    int bad;
    bad = -1;
    tests++;
    for (int i = 31; i >= 0; i--)
      if (curr_general_reg[32*i +: 32] !== exp[32*i +: 32]) bad = i;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s x%0d got %h exp %h", nm, bad,
               curr_general_reg[32*bad +: 32], exp[32*bad +: 32]);
    end
  endtask

  function automatic logic [63:0] exp_ret(input logic [63:0] r);
`ifdef WB_RETIRE_COUNTER_EN
    return r;
`else
    return 64'h0 & r;
`endif
  endfunction

  task automatic model_reset();
    m_pc   = RPC;
    m_halt = 1'b0;
    m_ret  = '0;
    kred   = -1000;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    q.delete();
  endtask

  // architectural effect of a beat accepted at the coming edge
  task automatic model(input logic [31:0] pc, input logic [4:0] rd,
                       input logic we, input logic [31:0] v,
                       input logic r, input logic [31:0] t);
    int          e;
    logic [31:0] tg;
    exp_t        x;
    e = cyc + 1;
    if (!(e >= kred + 1 && e <= kred + D)) begin
      m_ret++;
      if (we && rd != 5'd0) m_x[rd] = v;
      if (r) begin
        tg = t & ~32'h1;
        if (tg[1]) m_halt = 1'b1;
        else begin
          m_pc = tg;
          kred = e;
        end
      end else begin
        m_pc = pc + 32'd4;
      end
    end
    x.pc  = m_pc;
    x.gpr = m_flat();
    x.mis = m_halt;
    x.ret = exp_ret(m_ret);
    q.push_back(x);
  endtask

  // monitor: per-cycle handshake/flush checks, scoreboard pop per accept
  always @(negedge clk) pend <= rst_n && in_valid && in_ready;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        chk("in_ready", 64'(in_ready), 64'(!hold && !m_halt));
        chk("flush", 64'(flush), 64'(cyc >= kred && cyc <= kred + D - 1));
        chk("misalign", 64'(misalign_err), 64'(m_halt));
        if (pend) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty got accept exp none");
          end else begin
            e = q.pop_front();
            chk("pc", 64'(curr_pc_reg), 64'(e.pc));
            chk_gpr("gpr", e.gpr);
            chk("retire_cnt", retire_cnt, e.ret);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    hold     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_pc", 64'(curr_pc_reg), 64'(RPC));
    chk_gpr("rst_gpr", '0);
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_mis", 64'(misalign_err), 64'(0));
    chk("rst_ret", retire_cnt, 64'h0);
    chk("rst_ready", 64'(in_ready), 64'(1));
  endtask

  task automatic beat(input logic [31:0] pc, input logic [4:0] rd,
                      input logic we, input logic [31:0] v,
                      input logic r, input logic [31:0] t, input int nh);
    bit ok;
    if (m_halt) return;
    @(posedge clk);
    #1;
    in_valid       = 1'b1;
    in_pc          = pc;
    in_rd          = rd;
    in_rd_we       = we;
    in_rd_value    = v;
    in_redirect    = r;
    in_next_pc_reg = t;
    hold           = (nh > 0);
    ok             = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      if (in_ready && rst_n) begin
        model(pc, rd, we, v, r, t);
        ok = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (nh > 0) nh--;
        hold = (nh > 0);
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout got no accept exp accept");
    end
  endtask

  task automatic idle(input int n, input bit rh);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      hold     = rh ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    hold           = 1'b0;
    in_pc          = '0;
    in_rd          = '0;
    in_rd_we       = 1'b0;
    in_rd_value    = '0;
    in_redirect    = 1'b0;
    in_next_pc_reg = '0;
    tests          = 0;
    fails          = 0;
    model_reset();

    do_reset();
    beat(32'h100, 5'd5, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 0);
    beat(32'h104, 5'd0, 1'b1, 32'h0000_1234, 1'b0, 32'h0, 0);
    beat(32'h104, 5'd1, 1'b1, 32'h0000_0108, 1'b1, 32'h201, 0);
    beat(32'h200, 5'd6, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 0);
    beat(32'h204, 5'd7, 1'b1, 32'h2222_2222, 1'b1, 32'h400, 0);
    beat(32'h200, 5'd8, 1'b1, 32'h3333_3333, 1'b0, 32'h0, 0);
    beat(32'hFFFF_FFFC, 5'd9, 1'b0, 32'h0, 1'b0, 32'h0, 0);
    beat(32'h0, 5'd10, 1'b1, 32'hA5A5_A5A5, 1'b0, 32'h0, 3);
    beat(32'h4, 5'd11, 1'b1, 32'h5A5A_5A5A, 1'b1, 32'h1000, 0);
    idle(3, 1'b0);
    beat(32'h1000, 5'd2, 1'b1, 32'h1004, 1'b1, 32'h202, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    chk("halt_pc", 64'(curr_pc_reg), 64'(32'h1000));
    chk("halt_link", 64'(curr_general_reg[64 +: 32]), 64'(32'h1004));
    do_reset();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2), 1'b1);
      t = $urandom() & ~32'h2;
      if ($urandom_range(0, 39) == 0) t = t | 32'h2;
      beat($urandom() & ~32'h3, 5'($urandom()), 1'($urandom()),
           $urandom(), ($urandom_range(0, 3) == 0), t,
           ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      if (m_halt) begin
        idle(2, 1'b0);
        do_reset();
      end else if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end
    end

    idle(4, 1'b0);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage. It is the consumer end of the exec-to-writeback interface.
- Accepts one result per beat from exec over a valid/ready handshake and commits it architecturally.
- Owns the 32x32 general register file and the PC register, and feeds both back to exec through the top-to-exec path.
- On a taken branch or jump it redirects the PC and drives a flush window that discards wrong-path results.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- FLUSH_DEPTH, 2, number of cycles the flush window lasts after a redirect commit (1..15).
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  exec presents a result this cycle
- in_ready  out  1  this stage accepts the result this cycle
- in_pc  in  32  PC of the instruction being retired
- in_rd  in  5  destination register index
- in_rd_we  in  1  instruction writes rd
- in_rd_value  in  32  value to write to rd
- in_redirect  in  1  branch taken, JAL, or JALR
- in_next_pc_reg  in  32  redirect target
- hold  in  1  top-level stall request
- curr_pc_reg  out  32  architectural PC, to exec/fetch
- curr_general_reg  out  1024  flattened x0..x31; x[i] occupies bits [32*i+31:32*i]
- flush  out  1  high during the flush window; fetch/decode/exec drop in-flight work
- misalign_err  out  1  sticky: a redirect target was misaligned
- retire_cnt  out  64  retired-instruction count (see Optional Feature)

Behaviour:
- Reset values (asynchronous on rst_n=0):
  - curr_pc_reg=RESET_PC
  - all 32 GPRs=0
  - flush=0, misalign_err=0, retire_cnt=0
  - state=RUN
- Handshake:
  - A beat is accepted when in_valid & in_ready at the clock edge.
  - in_ready = !hold && state!=HALT.
  - Once in_valid is raised, exec holds in_valid and all in_* inputs stable until the beat is accepted.
- Commit latency: one cycle. State written at the accept edge is visible on the outputs in the next cycle. There is no internal bypass; exec reads curr_general_reg only.
- State machine, 3 states:
  - RUN:
    - An accepted beat commits.
    - If the commit has in_redirect=1 and a legal target, go to FLUSH, load flush_cnt=FLUSH_DEPTH-1, and set flush=1 from the next cycle.
    - If the target is illegal, go to HALT.
  - FLUSH:
    - Accepted beats are discarded: no GPR, PC, or counter change.
    - flush=1 throughout.
    - flush_cnt decrements each cycle, including cycles where hold=1.
    - When flush_cnt==0, return to RUN with flush=0 in the following cycle.
  - HALT:
    - in_ready=0, misalign_err=1.
    - Left only by reset.
- Commit rules:
  - GPR: if in_rd_we && in_rd!=0, then x[in_rd] <= in_rd_value. Writes to x0 are ignored; x0 always reads 0.
  - PC, no redirect: curr_pc_reg <= in_pc + 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
  - PC, redirect: target = in_next_pc_reg & ~32'h1 (JALR bit-0 mask).
    - If target[1]==1: misaligned. The PC is not updated, but the GPR write (the link register) still commits. Enter HALT.
    - Otherwise curr_pc_reg <= target.
- Simultaneous events:
  - hold=1 with in_valid=1: no accept, no state change except flush_cnt decrement.
  - A redirect accepted in the same cycle that FLUSH ends is already in RUN, so it commits and restarts FLUSH.
- Reset mid-FLUSH or in HALT returns immediately to the reset values above.

Optional Feature:
- Macro: WB_RETIRE_COUNTER_EN.
- Defined:
  - retire_cnt is a 64-bit counter that increments by 1 on each committed beat in RUN, including a misaligned-redirect beat.
  - Discarded FLUSH beats do not count.
  - Wraps at 2^64.
- Undefined: no counter flops; retire_cnt is tied to 64'h0.

Test Plan:
- Reset with RESET_PC=32'h100 -> curr_pc_reg=0x100, all GPRs 0, flush=0, in_ready=1 after release.
- Commit in_pc=0x100, rd=5, we=1, value=0xDEADBEEF, no redirect -> next cycle x5=0xDEADBEEF, PC=0x104; second beat with rd=0, value=0x1234 -> x0 stays 0.
- Redirect beat in_pc=0x104, rd=1, value=0x108, target=0x201 -> x1=0x108, PC=0x200, flush high for exactly 2 cycles; two beats accepted during flush leave GPRs and PC unchanged.
- Redirect target=0x202 -> PC unchanged, link written, misalign_err=1, in_ready=0 until rst_n pulse.
- hold=1 for 3 cycles with in_valid=1 -> in_ready=0 and no commit; beat commits on the first cycle after hold drops.
- With WB_RETIRE_COUNTER_EN: 10 commits plus 2 flushed beats -> retire_cnt=10. Without the macro: retire_cnt=0 throughout.
